disp_scan_ctrl: RTL

Parametrised, time-multiplexed driver for a bank of N_DIGITS common-segment 7-segment displays. Latches a packed multi-digit hex/BCD value into a shadow register and scans one digit at a time at a prescaled rate. For the active digit it drives the anode select, the full hex segment pattern and the decimal point. Adds per-digit blanking, leading-zero suppression and selectable output polarity. Sits between the datapath/result registers and the board display pins.

---
 rtl/disp_scan_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan driver: shadows a packed hex value and walks
// the anodes one digit per prescaler period, with blanking, leading-zero suppression and pin polarity.
module disp_scan_ctrl #(
    parameter int N_DIGITS       = 4,
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    localparam int IDX_W = $clog2((N_DIGITS > 2) ? N_DIGITS : 2),
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done
);

    logic [PRE_W-1:0]      presc;
    logic [IDX_W-1:0]      idx;
    logic                  tick;
    logic [4*N_DIGITS-1:0] sh_value;
    logic [N_DIGITS-1:0]   sh_dp;
    logic [N_DIGITS-1:0]   sh_blank;

    logic [N_DIGITS-1:0]   lz_dark;
    logic [N_DIGITS-1:0]   an_sel;
    logic                  zero_above;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  cur_lz;
    logic                  dark;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h7E;
            4'h1: seg_decode = 7'h30;
            4'h2: seg_decode = 7'h6D;
            4'h3: seg_decode = 7'h79;
            4'h4: seg_decode = 7'h33;
            4'h5: seg_decode = 7'h5B;
            4'h6: seg_decode = 7'h5F;
            4'h7: seg_decode = 7'h70;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h7B;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h1F;
            4'hC: seg_decode = 7'h4E;
            4'hD: seg_decode = 7'h3D;
            4'hE: seg_decode = 7'h4F;
            default: seg_decode = 7'h47;
        endcase
    endfunction

    assign tick = (presc == PRE_W'(CLK_DIV - 1));

    // frame_done is registered alongside the idx wrap so it lines up with idx returning to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                presc <= '0;
                if (idx == IDX_W'(N_DIGITS - 1)) begin
                    idx        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                presc <= presc + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
        end else if (load) begin
            sh_value <= value;
            sh_dp    <= dp_in;
            sh_blank <= blank;
        end
    end

    // Suppression walks down from the top digit; digit 0 always stays lit
    always_comb begin
        lz_dark    = '0;
        an_sel     = '0;
        zero_above = 1'b1;
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_lz     = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (sh_value[4*i +: 4] == 4'h0);
            lz_dark[i] = lz_en && zero_above && (i != 0);
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = sh_value[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_blank = sh_blank[i];
                cur_lz    = lz_dark[i];
                an_sel[i] = 1'b1;
            end
        end
        dark = cur_blank | cur_lz;
    end

    // Polarity is applied last so dark digits and reset both land on the "off" level
    always_ff @(posedge clk) begin
        if (rst) begin
            seg       <= {7{SEG_ACTIVE_LOW}};
            dp        <= SEG_ACTIVE_LOW;
            an        <= {N_DIGITS{AN_ACTIVE_LOW}};
            digit_idx <= '0;
        end else begin
            seg       <= (dark ? 7'h00 : seg_decode(cur_nib)) ^ {7{SEG_ACTIVE_LOW}};
            dp        <= (cur_dp & ~dark) ^ SEG_ACTIVE_LOW;
            an        <= an_sel ^ {N_DIGITS{AN_ACTIVE_LOW}};
            digit_idx <= idx;
        end
    end

endmodule
